// File: rtl/axi4_ring_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between ring writer and memory.
// master drives aw*/w*/bready; slave drives awready/wready/bresp/bvalid.
interface axi4_ring_writer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi4_ring_writer.sv
// AXI4 ring writer: buffers a 32-bit sample stream and writes fixed
// INCR bursts into a circular DDR buffer, one transaction in flight.
// Ports: aclk/areset (sync, active-high), cfg_* run config, s_t* sample
// stream, m_axi write master, wr_offset/busy/err status.
// Option AXI4_RING_WRITER_WRAP_IRQ_EN adds wrap_irq and wrap_count.
module axi4_ring_writer #(
  parameter int BURST_LEN  = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cfg_enable,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_ring_bytes,
  input  logic [31:0]           s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  axi4_ring_writer_if.master    m_axi,
  output logic [ADDR_WIDTH-1:0] wr_offset,
  output logic                  busy,
  output logic                  err
`ifdef AXI4_RING_WRITER_WRAP_IRQ_EN
  ,
  output logic                  wrap_irq,
  output logic [15:0]           wrap_count
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_LEN * 4);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] NEED = (PW+1)'(BURST_LEN);
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state;
  state_t                nxt;
  logic                  en_q;
  logic                  en_qq;
  logic                  en_rise;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] ring_q;
  logic [ADDR_WIDTH-1:0] off_next;
  logic [31:0]           mem [FIFO_DEPTH];
  logic [PW:0]           wptr;
  logic [PW:0]           rptr;
  logic [PW:0]           count;
  logic [BW-1:0]         beat;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  last;
  logic                  have;
  logic                  resp_done;
  logic                  wrap;

  assign en_rise   = en_q && !en_qq;
  assign count     = wptr - rptr;
  assign s_tready  = en_q && (count != DEPTH);
  assign push      = s_tvalid && s_tready;
  assign have      = count >= NEED;
  assign last      = beat == LAST;
  assign pop       = (state == DATA) && m_axi.wready;
  // Idle while disabled: drop any partial burst left in the FIFO.
  assign flush     = (state == IDLE) && !en_q;
  assign resp_done = (state == RESP) && m_axi.bvalid;
  assign off_next  = wr_offset + STEP;
  assign wrap      = off_next == ring_q;

  assign m_axi.awaddr  = base_q + wr_offset;
  assign m_axi.awlen   = 8'(BURST_LEN - 1);
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awvalid = state == ADDR;
  assign m_axi.wdata   = mem[rptr[PW-1:0]];
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = state == DATA;
  assign m_axi.wlast   = (state == DATA) && last;
  assign m_axi.bready  = state == RESP;
  assign busy          = state != IDLE;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (en_q && have) nxt = ADDR;
      ADDR: if (m_axi.awready) nxt = DATA;
      DATA: if (m_axi.wready && last) nxt = RESP;
      RESP: if (m_axi.bvalid) nxt = (en_q && have) ? ADDR : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      en_q      <= 1'b0;
      en_qq     <= 1'b0;
      base_q    <= '0;
      ring_q    <= '0;
      wptr      <= '0;
      rptr      <= '0;
      beat      <= '0;
      wr_offset <= '0;
      err       <= 1'b0;
    end else begin
      state <= nxt;
      en_q  <= cfg_enable;
      en_qq <= en_q;
      if (en_rise) begin
        base_q <= cfg_base_addr;
        ring_q <= cfg_ring_bytes;
      end
      if (push) wptr <= wptr + (PW+1)'(1);
      if (flush) rptr <= wptr;
      else if (pop) rptr <= rptr + (PW+1)'(1);
      if (pop) beat <= last ? '0 : beat + BW'(1);
      if (resp_done) wr_offset <= wrap ? '0 : off_next;
      else if (flush) wr_offset <= '0;
      // A bad response in the same cycle as re-enable still sticks.
      if (resp_done && m_axi.bresp != 2'b00) err <= 1'b1;
      else if (en_rise) err <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wptr[PW-1:0]] <= s_tdata;
  end

`ifdef AXI4_RING_WRITER_WRAP_IRQ_EN
  assign wrap_irq = resp_done && wrap;

  always_ff @(posedge aclk) begin
    if (areset) wrap_count <= '0;
    else if (wrap_irq && wrap_count != 16'hFFFF)
      wrap_count <= wrap_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_axi4_ring_writer.sv
// Scoreboard bench for axi4_ring_writer: directed stream scenarios,
// AXI slave model, queue-based monitor on AW/W/B handshakes.
module tb_axi4_ring_writer;
  logic        aclk = 1'b0;
  logic        areset;
  logic        cfg_enable;
  logic [31:0] cfg_base_addr;
  logic [31:0] cfg_ring_bytes;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] wr_offset;
  logic        busy;
  logic        err;
`ifdef AXI4_RING_WRITER_WRAP_IRQ_EN
  logic        wrap_irq;
  logic [15:0] wrap_count;
`endif

  axi4_ring_writer_if #(.ADDR_WIDTH(32)) m_axi ();

  axi4_ring_writer dut (
    .aclk           (aclk),
    .areset         (areset),
    .cfg_enable     (cfg_enable),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_ring_bytes (cfg_ring_bytes),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .m_axi          (m_axi),
    .wr_offset      (wr_offset),
    .busy           (busy),
    .err            (err)
`ifdef AXI4_RING_WRITER_WRAP_IRQ_EN
    ,
    .wrap_irq       (wrap_irq),
    .wrap_count     (wrap_count)
`endif
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  int wbeat = 0;
  int nb = 0;
  int err_at = 0;
  int aw_delay = 0;
  int aw_cnt = 0;
  bit wr_rand = 0;
  bit track_err = 0;
  bit err_exp = 0;
  bit chk_full_en = 0;
  bit saw_full = 0;
  int n_acc = 0;
  int n_pop = 0;
  int occ;
  int n_wrap = 0;
  int last_acc_cyc = 0;
  int aw_rise_cyc = 0;
  bit aw_prev = 0;
  bit aw_hold = 0;
  logic [31:0] aw_held;
  bit w_hold = 0;
  logic [31:0] w_held;
  int nb0;

  always @(posedge aclk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name, input int act, input int req);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d want %0d (timeout)", name, act, req);
  endtask

  // AXI slave: configurable AW delay, random W stalls, B always valid.
  initial begin
    m_axi.awready = 1'b0;
    m_axi.wready  = 1'b0;
    m_axi.bvalid  = 1'b0;
    m_axi.bresp   = 2'b00;
    forever begin
      @(posedge aclk);
      #1;
      if (!m_axi.awvalid) begin
        aw_cnt = 0;
        m_axi.awready = (aw_delay == 0);
      end else if (aw_cnt < aw_delay) begin
        aw_cnt++;
        m_axi.awready = 1'b0;
      end else begin
        m_axi.awready = 1'b1;
      end
      m_axi.wready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi.bvalid = 1'b1;
      m_axi.bresp  = (nb + 1 == err_at) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: pops expectations whenever a handshake is presented.
  always @(negedge aclk) begin
    occ = n_acc - n_pop;
    if (chk_full_en && s_tvalid && !s_tready) begin
      chk("full_stall_occ", 64'(occ), 64'd32);
      saw_full = 1;
    end
    if (s_tvalid && s_tready) begin
      n_acc++;
      last_acc_cyc = cyc;
    end
    if (m_axi.awvalid && !aw_prev) aw_rise_cyc = cyc;
    aw_prev = m_axi.awvalid;
    if (aw_hold && m_axi.awvalid)
      chk("awaddr_stable", m_axi.awaddr, aw_held);
    aw_hold = m_axi.awvalid && !m_axi.awready;
    aw_held = m_axi.awaddr;
    if (m_axi.awvalid && m_axi.awready) begin
      if (exp_addr.size() == 0)
        chk("aw_queue", 64'(exp_addr.size()), 64'd1);
      else
        chk("awaddr", m_axi.awaddr, exp_addr.pop_front());
      chk("awlen", m_axi.awlen, 64'd15);
      chk("awsize_burst", {m_axi.awsize, m_axi.awburst}, 64'b01001);
    end
    if (w_hold && m_axi.wvalid)
      chk("wdata_stable", m_axi.wdata, w_held);
    w_hold = m_axi.wvalid && !m_axi.wready;
    w_held = m_axi.wdata;
    if (m_axi.wvalid && m_axi.wready) begin
      if (exp_data.size() == 0)
        chk("w_queue", 64'(exp_data.size()), 64'd1);
      else
        chk("wdata", m_axi.wdata, exp_data.pop_front());
      chk("wlast", m_axi.wlast, 64'(wbeat == 15));
      chk("wstrb", m_axi.wstrb, 64'hF);
      wbeat = (wbeat + 1) % 16;
      n_pop++;
    end
    if (track_err) chk("err_track", err, err_exp);
    if (m_axi.bvalid && m_axi.bready) begin
      if (m_axi.bresp != 2'b00) err_exp = 1;
      nb++;
    end
`ifdef AXI4_RING_WRITER_WRAP_IRQ_EN
    if (wrap_irq) n_wrap++;
`endif
  end

  task automatic send(input int n, input int first);
    bit ok;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'(first + i);
      ok = 0;
      for (int t = 0; t < 2000 && !ok; t++) begin
        @(negedge aclk);
        if (s_tready) ok = 1;
        @(posedge aclk);
        #1;
      end
      if (!ok) timeout("send_ready", i, n);
      exp_data.push_back(32'(first + i));
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_bursts(input int target);
    int t;
    t = 0;
    while ((nb < target || busy) && t < 4000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 4000) timeout("burst_wait", nb, target);
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_beat(input int n);
    int t;
    t = 0;
    while (wbeat < n && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 2000) timeout("beat_wait", wbeat, n);
    @(posedge aclk);
    #1;
  endtask

  task automatic restart(input logic [31:0] ring);
    cfg_enable = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    cfg_ring_bytes = ring;
    cfg_enable = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    cfg_enable = 1'b0;
    cfg_base_addr = 32'h1000_0000;
    cfg_ring_bytes = 32'h400;
    s_tvalid = 1'b0;
    s_tdata = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awvalid", m_axi.awvalid, 0);
    chk("rst_wvalid", m_axi.wvalid, 0);
    chk("rst_wlast", m_axi.wlast, 0);
    chk("rst_bready", m_axi.bready, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_offset", wr_offset, 0);
    chk("rst_busy_err", {busy, err}, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Single burst, plus AW latency after the 16th sample.
    cfg_enable = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    exp_addr.push_back(32'h1000_0000);
    send(16, 0);
    wait_bursts(1);
    chk("aw_latency", 64'(aw_rise_cyc - last_acc_cyc), 64'd2);
    chk("single_offset", wr_offset, 32'h40);
    chk("single_busy", busy, 0);

    // Ring wrap with a 128-byte ring.
    restart(32'h80);
    chk("restart_offset", wr_offset, 0);
    exp_addr.push_back(32'h1000_0000);
    exp_addr.push_back(32'h1000_0040);
    exp_addr.push_back(32'h1000_0000);
    send(48, 100);
    wait_bursts(4);
    chk("wrap_offset", wr_offset, 32'h40);
`ifdef AXI4_RING_WRITER_WRAP_IRQ_EN
    chk("wrap_pulses", 64'(n_wrap), 64'd1);
    chk("wrap_count", wrap_count, 64'd1);
`endif

    // Backpressure: AW delayed 5 cycles, W randomly stalled.
    restart(32'h400);
    n_acc = 0;
    n_pop = 0;
    aw_delay = 5;
    wr_rand = 1;
    chk_full_en = 1;
    exp_addr.push_back(32'h1000_0000);
    exp_addr.push_back(32'h1000_0040);
    exp_addr.push_back(32'h1000_0080);
    exp_addr.push_back(32'h1000_00C0);
    send(64, 200);
    wait_bursts(8);
    chk_full_en = 0;
    aw_delay = 0;
    wr_rand = 0;
    chk("bp_saw_full", saw_full, 1);
    chk("bp_offset", wr_offset, 32'h100);

    // Error response on the 2nd burst; streaming continues.
    restart(32'h400);
    nb0 = nb;
    err_at = nb0 + 2;
    err_exp = 0;
    track_err = 1;
    exp_addr.push_back(32'h1000_0000);
    exp_addr.push_back(32'h1000_0040);
    exp_addr.push_back(32'h1000_0080);
    send(48, 300);
    wait_bursts(nb0 + 3);
    track_err = 0;
    chk("err_set", err, 1);
    chk("err_offset", wr_offset, 32'hC0);
    restart(32'h400);
    chk("err_cleared", err, 0);

    // Disable at beat 5 with 20 samples queued.
    nb0 = nb;
    exp_addr.push_back(32'h1000_0000);
    send(20, 600);
    wait_beat(5);
    cfg_enable = 1'b0;
    wait_bursts(nb0 + 1);
    repeat (3) @(posedge aclk);
    #1;
    chk("dis_residual", 64'(exp_data.size()), 64'd4);
    chk("dis_offset", wr_offset, 0);
    chk("dis_busy", busy, 0);
    exp_data.delete();
    cfg_enable = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    nb0 = nb;
    err_at = nb0 + 1;
    exp_addr.push_back(32'h1000_0000);
    send(16, 700);
    wait_bursts(nb0 + 1);
    chk("dis_err_set", err, 1);

    // Reset at beat 8.
    exp_addr.push_back(32'h1000_0040);
    send(16, 800);
    wait_beat(8);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("mrst_awvalid", m_axi.awvalid, 0);
    chk("mrst_wvalid", m_axi.wvalid, 0);
    chk("mrst_bready", m_axi.bready, 0);
    chk("mrst_offset", wr_offset, 0);
    chk("mrst_err", err, 0);
    chk("mrst_busy", busy, 0);
    @(posedge aclk);
    #1;
    exp_data.delete();
    exp_addr.delete();
    wbeat = 0;
    repeat (3) @(posedge aclk);
    #1;
    nb0 = nb;
    exp_addr.push_back(32'h1000_0000);
    send(16, 900);
    wait_bursts(nb0 + 1);
    chk("post_rst_offset", wr_offset, 32'h40);
    chk("end_addr_q", 64'(exp_addr.size()), 0);
    chk("end_data_q", 64'(exp_data.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi4_ring_writer.md
Name: axi4_ring_writer

Overview:
- Sequencing controller for the AXI4 master write path to DDR; the memory side is a slave memory model in simulation.
- Accepts a 32-bit sample stream and buffers it in an internal FIFO.
- Issues fixed-length INCR write bursts into a circular buffer in memory, holding at most one outstanding transaction.
- Reports the current write pointer and a sticky response error to the register bank.

Parameters:
- BURST_LEN, 16, beats per burst; power of two, 2..256.
- ADDR_WIDTH, 32, AXI address width.
- FIFO_DEPTH, 32, sample FIFO depth; power of two, at least BURST_LEN.

Ports:
- aclk  in  1  system clock; all logic is on its rising edge.
- areset  in  1  synchronous, active-high reset.
- cfg_enable  in  1  run enable.
- cfg_base_addr  in  ADDR_WIDTH  ring base; must be aligned to BURST_LEN*4.
- cfg_ring_bytes  in  ADDR_WIDTH  ring size in bytes; nonzero multiple of BURST_LEN*4.
- s_tdata  in  32  sample data.
- s_tvalid  in  1  sample valid.
- s_tready  out  1  FIFO not full.
- m_axi_awaddr  out  ADDR_WIDTH  burst address.
- m_axi_awlen  out  8  constant BURST_LEN-1.
- m_axi_awsize  out  3  constant 3'b010.
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  constant 4'hF.
- m_axi_wlast  out  1  last beat of the burst.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.
- wr_offset  out  ADDR_WIDTH  byte offset of the next burst within the ring.
- busy  out  1  state is not IDLE.
- err  out  1  sticky bad-response flag.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - State goes to IDLE; the FIFO is emptied.
  - wr_offset=0, err=0, busy=0.
  - awvalid=0, wvalid=0, wlast=0, bready=0, s_tready=0.
  - Reset mid-burst aborts immediately; the interconnect shares this reset.
- FIFO:
  - A sample is written when s_tvalid&&s_tready.
  - s_tready = enable_q && !full, where enable_q is cfg_enable registered.
  - Simultaneous push and pop in the same cycle keeps the count unchanged.
- State machine IDLE -> ADDR -> DATA -> RESP:
  - IDLE: when enable_q=1 and fifo_count>=BURST_LEN, go to ADDR. cfg_base_addr and cfg_ring_bytes are latched on the cycle enable_q rises.
  - ADDR: awvalid=1 and awaddr = base + wr_offset, held stable until awready. Go to DATA on the cycle after the handshake.
  - DATA:
    - wvalid=1 and wdata = FIFO head; pop on wvalid&&wready.
    - Beat counter runs 0..BURST_LEN-1; wlast=1 on beat BURST_LEN-1.
    - AW and W are never overlapped. The FIFO cannot underflow, because a full burst is present on entry.
  - RESP:
    - bready=1. On bvalid, if bresp!=2'b00 then err<=1.
    - On the same cycle, wr_offset <= wr_offset + BURST_LEN*4; if the result equals the latched ring size, it wraps to 0.
    - Next state is ADDR if enable_q=1 and fifo_count>=BURST_LEN, otherwise IDLE.
- Disable:
  - Deasserting cfg_enable never truncates a burst; the current burst completes through RESP.
  - Entering IDLE with enable_q=0 flushes residual FIFO words (fewer than BURST_LEN) and resets wr_offset to 0.
- err clears only on areset or on a rising edge of enable_q.
- Bursts never cross a 4 KB boundary, given the required base alignment and BURST_LEN*4 ≤ 1024.
- Latency: the first awvalid rises 2 cycles after the BURST_LEN-th sample is accepted.

Optional Feature:
- Macro: AXI4_RING_WRITER_WRAP_IRQ_EN.
- When defined:
  - Adds output port wrap_irq (1 bit), reset value 0.
  - wrap_irq is a one-cycle pulse on the RESP cycle where wr_offset wraps to 0.
  - Adds output wrap_count (16 bits), reset value 0, incremented on each wrap; it saturates at 16'hFFFF.
- When undefined: neither port exists and no logic is generated.

Test Plan:
- Single burst:
  - Stimulus: base=0x1000_0000, ring=0x400, stream 16 samples 0..15, awready/wready/bvalid always 1.
  - Expected: one burst, awaddr=0x1000_0000, awlen=15, data 0..15, wlast on beat 15, then wr_offset=0x40 and busy=0.
- Ring wrap:
  - Stimulus: ring=0x80, stream 48 samples.
  - Expected: awaddr sequence 0x1000_0000, 0x1000_0040, 0x1000_0000; wr_offset ends at 0x40.
  - With the macro defined: exactly one wrap_irq pulse and wrap_count=1.
- Backpressure:
  - Stimulus: wready randomly low 50%, awready delayed 5 cycles, continuous input.
  - Expected: s_tready drops when the FIFO holds 32 samples; no samples lost or reordered; addresses stay stable while their valid is high.
- Error response:
  - Stimulus: slave returns bresp=2'b10 on the 2nd burst.
  - Expected: err=1 from the RESP cycle onward and streaming continues. Toggling cfg_enable 0->1 clears err.
- Disable mid-burst:
  - Stimulus: drop cfg_enable at beat 5 of a burst with 20 samples queued.
  - Expected: the burst completes all 16 beats with wlast; the remaining 4 samples are flushed; wr_offset=0 and busy=0.
- Reset mid-burst:
  - Stimulus: assert areset for 1 cycle at beat 8.
  - Expected: the next cycle shows awvalid=0, wvalid=0, bready=0, wr_offset=0, err=0, and an empty FIFO.
